// File: rtl/sps_pkg.sv
// Shared constants, glyph table and snapshot payload for the parking-lot
// seven-segment display driver.
package sps_pkg;

  localparam int unsigned N_DIGITS   = 5;
  localparam int unsigned N_SLOTS    = 4;
  localparam int unsigned SEG_W      = 8;
  localparam int unsigned PTR_W      = 3;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned SLOT_IDX_W = 2;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t GLYPH_0     = 8'h3F;
  localparam seg_t GLYPH_1     = 8'h06;
  localparam seg_t GLYPH_2     = 8'h5B;
  localparam seg_t GLYPH_3     = 8'h4F;
  localparam seg_t GLYPH_4     = 8'h66;
  localparam seg_t GLYPH_F     = 8'h71;
  localparam seg_t GLYPH_DASH  = 8'h40;
  localparam seg_t GLYPH_OCC   = 8'h06;
  localparam seg_t GLYPH_BLANK = 8'h00;
  localparam seg_t SEG_DP      = 8'h80;

  localparam logic [N_DIGITS-1:0] SEG_OFF = 5'b11111;

  typedef struct packed {
    logic [N_SLOTS-1:0] spots;
    logic               full;
    logic               door;
  } snap_t;

  function automatic seg_t count_glyph(logic [CNT_W-1:0] n);
    case (n)
      3'd0:    count_glyph = GLYPH_0;
      3'd1:    count_glyph = GLYPH_1;
      3'd2:    count_glyph = GLYPH_2;
      3'd3:    count_glyph = GLYPH_3;
      3'd4:    count_glyph = GLYPH_4;
      default: count_glyph = GLYPH_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/sps_seg_display_if.sv
// Occupancy inputs and segment-pin outputs of the display driver.
interface sps_seg_display_if import sps_pkg::*; ;

  logic [N_SLOTS-1:0]  spots;
  logic                full;
  logic                door_open;
  logic [N_DIGITS-1:0] SEG_SEL;
  seg_t                SEG_DATA;
  logic                frame_start;

  modport master (
    output spots, full, door_open,
    input  SEG_SEL, SEG_DATA, frame_start
  );

  modport slave (
    input  spots, full, door_open,
    output SEG_SEL, SEG_DATA, frame_start
  );

endinterface

// File: rtl/sps_seg_encode.sv
// Combinational glyph selection for the digit under the scan pointer.
module sps_seg_encode
  import sps_pkg::*;
(
  input  logic [PTR_W-1:0] ptr_i,
  input  snap_t            snap_i,
  input  logic             blink_on_i,
  output seg_t             seg_c_o
);

  logic [CNT_W-1:0] occ_cnt;
  logic [CNT_W-1:0] free_cnt;

  always_comb begin
    occ_cnt = '0;
    for (int i = 0; i < int'(N_SLOTS); i++) begin
      occ_cnt = occ_cnt + CNT_W'(snap_i.spots[i]);
    end
    free_cnt = CNT_W'(N_SLOTS) - occ_cnt;
  end

  // Digits 0..3 are per-slot status; the last digit is count, "F" or blank, plus door dp.
  always_comb begin
    seg_c_o = GLYPH_BLANK;
    if (ptr_i < PTR_W'(N_SLOTS)) begin
      seg_c_o = snap_i.spots[ptr_i[SLOT_IDX_W-1:0]] ? GLYPH_OCC : GLYPH_DASH;
    end else begin
      if (snap_i.full) begin
        seg_c_o = blink_on_i ? GLYPH_F : GLYPH_BLANK;
      end else begin
        seg_c_o = count_glyph(free_cnt);
      end
      if (snap_i.door) begin
        seg_c_o = seg_c_o | SEG_DP;
      end
    end
  end

endmodule

// File: rtl/sps_seg_display.sv
// Five-digit multiplexed seven-segment driver: prescaler, digit scan,
// per-frame input snapshot, blink timing and registered pin outputs.
module sps_seg_display
  import sps_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 40000,
  parameter int unsigned BLANK_CYCLES = 4,
  parameter int unsigned BLINK_FRAMES = 100
) (
  input  logic             clk,
  input  logic             reset_in,
  sps_seg_display_if.slave bus
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [DIV_W-1:0]    div_q, div_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  snap_t               snap_q, snap_d;
  logic [BLK_W-1:0]    blk_cnt_q, blk_cnt_d;
  logic                blink_on_q, blink_on_d;
  logic                cap_q, cap_d;
  logic [N_DIGITS-1:0] seg_sel_q, seg_sel_d;
  seg_t                seg_data_q, seg_data_d;
  logic                frame_start_q, frame_start_d;

  logic tick_c;
  logic wrap_c;
  logic blank_c;
  seg_t glyph_c;

  sps_seg_encode u_encode (
    .ptr_i      (ptr_q),
    .snap_i     (snap_q),
    .blink_on_i (blink_on_q),
    .seg_c_o    (glyph_c)
  );

  assign tick_c  = (div_q == DIV_W'(SCAN_DIV - 1));
  assign wrap_c  = tick_c && (ptr_q == PTR_W'(N_DIGITS - 1));
  // Written as (div+1) <= N so a zero blanking window stays a plain compare.
  assign blank_c = ((32'(div_q) + 32'd1) <= BLANK_CYCLES);

  always_comb begin
    div_d         = div_q;
    ptr_d         = ptr_q;
    snap_d        = snap_q;
    blk_cnt_d     = blk_cnt_q;
    blink_on_d    = blink_on_q;
    cap_d         = wrap_c;
    seg_sel_d     = SEG_OFF;
    seg_data_d    = GLYPH_BLANK;
    frame_start_d = cap_q;

    div_d = tick_c ? '0 : div_q + DIV_W'(1);

    if (tick_c) begin
      ptr_d = wrap_c ? '0 : ptr_q + PTR_W'(1);
    end

    // Snapshot and blink step once per frame, on the last digit's final tick.
    if (wrap_c) begin
      snap_d = '{spots: bus.spots, full: bus.full, door: bus.door_open};
      if (blk_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
        blk_cnt_d  = '0;
        blink_on_d = ~blink_on_q;
      end else begin
        blk_cnt_d  = blk_cnt_q + BLK_W'(1);
      end
    end

    if (!blank_c) begin
      seg_sel_d  = ~(N_DIGITS'(1) << ptr_q);
      seg_data_d = glyph_c;
    end
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      div_q         <= '0;
      ptr_q         <= '0;
      snap_q        <= '0;
      blk_cnt_q     <= '0;
      blink_on_q    <= 1'b1;
      cap_q         <= 1'b0;
      seg_sel_q     <= SEG_OFF;
      seg_data_q    <= GLYPH_BLANK;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      ptr_q         <= ptr_d;
      snap_q        <= snap_d;
      blk_cnt_q     <= blk_cnt_d;
      blink_on_q    <= blink_on_d;
      cap_q         <= cap_d;
      seg_sel_q     <= seg_sel_d;
      seg_data_q    <= seg_data_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.SEG_SEL     = seg_sel_q;
  assign bus.SEG_DATA    = seg_data_q;
  assign bus.frame_start = frame_start_q;

endmodule
